fifo_push_arbiter: RTL and testbench
====================================

Name: fifo_push_arbiter

Overview:
- Shares the push port of one req/ack FIFO among N_REQ requesters.
- Arbitration is round-robin, and a grant is locked until a handshake completes.
- Each requester may make at most MAX_BURST consecutive pushes before the grant rotates.
- Sits between the producer agents and the FIFO push interface (push_req/push_ack/data_in). It obeys the FIFO protocol: once push_req is raised, push_req and data are held stable until push_ack.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- WIDTH, 4, data width per requester.
- IDW, 2, grant index width, equal to ceil(log2(N_REQ)).
- MAX_BURST, 4, max consecutive handshakes per grant (>=1).
- BCW, 3, burst counter width, equal to ceil(log2(MAX_BURST))+1.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-high reset.
- req_i, input, N_REQ, per-requester push request; must stay high with stable data until its ack_o.
- data_i, input, N_REQ*WIDTH, packed data; requester k occupies bits [k*WIDTH +: WIDTH].
- ack_o, output, N_REQ, per-requester acknowledge; at most one bit high.
- fifo_push_req, output, 1, push request to the FIFO.
- fifo_data_in, output, WIDTH, push data to the FIFO.
- fifo_push_ack, input, 1, FIFO push acknowledge; never high while the FIFO is full.
- grant_valid, output, 1, a requester currently holds the grant.
- grant_id, output, IDW, index of the granted requester; 0 when grant_valid=0.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0.
  - grant_valid=0, fifo_push_req=0, ack_o=0, fifo_data_in=0.
  - Reset asserted mid-operation drops fifo_push_req and ack_o immediately, without waiting for a clock edge. An in-flight unacked request is simply re-arbitrated after reset.
- States: IDLE, GRANT. grant_valid=(state==GRANT).
- IDLE:
  - fifo_push_req=0; fifo_data_in=0.
  - If any req_i bit is high, the winner is the first requester with req_i high, searching rr_ptr, rr_ptr+1, ... and wrapping modulo N_REQ.
  - Next cycle: state=GRANT, grant_id=winner, burst_cnt=0.
  - Arbitration latency is 1 cycle from req_i rise to fifo_push_req rise.
- GRANT, with g=grant_id:
  - fifo_push_req=req_i[g] and fifo_data_in=data_i[g]. These are combinational, zero latency.
  - ack_o[g]=fifo_push_ack & req_i[g]; all other ack_o bits are 0.
  - hsk = req_i[g] & fifo_push_ack.
- GRANT transitions, evaluated in priority order:
  1. hsk and burst_cnt==MAX_BURST-1 -> IDLE; rr_ptr=(g+1) mod N_REQ; burst_cnt=0.
  2. hsk -> stay in GRANT; burst_cnt+1.
  3. !req_i[g] -> IDLE; rr_ptr=(g+1) mod N_REQ; burst_cnt=0. This is only legal after a prior handshake; the requester finished its burst early.
  4. Otherwise (req high, no ack, e.g. FIFO full) -> hold state, grant_id and burst_cnt unchanged. The grant never moves while a request is pending unacked, which keeps fifo_push_req and data stable per FIFO protocol.
- Wrap-around: rr_ptr from N_REQ-1 goes to 0. When N_REQ is not a power of 2, index arithmetic is modulo N_REQ, never 2^IDW.
- Simultaneous requests: only one is granted; the others wait in IDLE/GRANT with their req held.
- Fairness: every requester with req held high is granted within (N_REQ-1) grant periods. Each grant period lasts at most MAX_BURST handshakes plus FIFO stall cycles.
- Back-to-back:
  - After leaving GRANT, IDLE lasts exactly one cycle when any req is pending.
  - Throughput is MAX_BURST pushes per MAX_BURST+1 cycles when the FIFO never stalls.
- MAX_BURST=1: every handshake returns to IDLE.
- Behaviour is undefined if a requester drops req_i, or changes data, before its ack.

Test Plan:
- Single requester: req_i=4'b0100, data 4'hA, FIFO never full.
  - Cycle 1: grant_id=2.
  - Same cycle: fifo_push_req=1, fifo_data_in=4'hA, ack_o=4'b0100.
  - Four handshakes, then IDLE for 1 cycle, then re-grant to 2.
- All four requesting continuously, MAX_BURST=4, no stalls.
  - Grant order is 0,1,2,3,0.
  - Each grant carries exactly 4 acks.
  - No ack_o has more than one bit high.
- FIFO full stall: requester 1 granted, fifo_push_ack held 0 for 10 cycles.
  - grant_id stays 1; fifo_push_req=1 and data are stable all 10 cycles.
  - burst_cnt is unchanged.
  - Ack arrives on cycle 11.
- Early release: requester 3 drops req after 2 acks.
  - Returns to IDLE and rr_ptr=0.
  - With requesters 0 and 3 pending, the next grant is 0 (wrap-around).
- Reset mid-grant: assert reset while fifo_push_req=1 and no ack.
  - fifo_push_req, ack_o and grant_valid go to 0 asynchronously.
  - After release, arbitration restarts from rr_ptr=0.
- Scoreboard with N_REQ=3 (non-power-of-2), random reqs and FIFO stalls.
  - Per-requester push order is preserved.
  - grant_id is never 3.
  - Each active requester is served within 2 grant periods.

Source files
------------

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: shares one req/ack FIFO push port among N_REQ producers.
// Round-robin arbitration. A grant is held until the granted requester has
// either completed MAX_BURST handshakes or released its request after a
// handshake. While a granted request is pending and unacked, the grant never
// moves, so fifo_push_req and fifo_data_in stay stable as the FIFO protocol
// requires.
module fifo_push_arbiter #(
   parameter int N_REQ     = 4,
   parameter int WIDTH     = 4,
   parameter int IDW       = 2,
   parameter int MAX_BURST = 4,
   parameter int BCW       = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_i,
   input  logic [N_REQ*WIDTH-1:0] data_i,
   output logic [N_REQ-1:0]       ack_o,
   output logic                   fifo_push_req,
   output logic [WIDTH-1:0]       fifo_data_in,
   input  logic                   fifo_push_ack,
   output logic                   grant_valid,
   output logic [IDW-1:0]         grant_id
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDW-1:0]   r_rr_ptr;
   logic [IDW-1:0]   w_rr_ptr_nxt;
   logic [IDW-1:0]   r_grant_id;
   logic [IDW-1:0]   w_grant_id_nxt;
   logic [BCW-1:0]   r_burst_cnt;
   logic [BCW-1:0]   w_burst_cnt_nxt;

   logic [IDW-1:0]   w_winner;
   logic             w_any_req;
   logic [IDW-1:0]   w_grant_inc;
   logic             w_req_g;
   logic [WIDTH-1:0] w_data_g;
   logic             w_hsk;
   logic             w_last_beat;

   // Round-robin search: walk from rr_ptr upward (mod N_REQ); the lowest
   // offset with a request wins, so scan offsets high-to-low and let the last
   // hit stand.
   always_comb begin
      int j;
      j         = 0;
      w_winner  = '0;
      w_any_req = |req_i;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         j = int'(r_rr_ptr) + i;
         if (j >= N_REQ) j = j - N_REQ;
         if (req_i[IDW'(j)]) w_winner = IDW'(j);
      end
   end

   // Pointer to the requester after the current grant, wrapping at N_REQ
   // (not at 2^IDW) so non-power-of-two requester counts rotate correctly.
   always_comb begin
      w_grant_inc = '0;
      if (r_grant_id != IDW'(N_REQ - 1)) w_grant_inc = r_grant_id + 1'b1;
   end

   // Select the granted requester's request and data word.
   always_comb begin
      w_req_g  = 1'b0;
      w_data_g = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (r_grant_id == IDW'(k)) begin
            w_req_g  = req_i[k];
            w_data_g = data_i[k*WIDTH +: WIDTH];
         end
      end
   end

   assign w_hsk       = (r_state == GRANT) && w_req_g && fifo_push_ack;
   assign w_last_beat = (r_burst_cnt == BCW'(MAX_BURST - 1));

   // FIFO-side and requester-side outputs; purely combinational from the
   // grant so a reset drops them without waiting for a clock edge.
   always_comb begin
      fifo_push_req = 1'b0;
      fifo_data_in  = '0;
      ack_o         = '0;
      grant_valid   = 1'b0;
      grant_id      = '0;
      if (r_state == GRANT) begin
         grant_valid   = 1'b1;
         grant_id      = r_grant_id;
         fifo_push_req = w_req_g;
         fifo_data_in  = w_data_g;
         for (int k = 0; k < N_REQ; k++) begin
            if (r_grant_id == IDW'(k)) ack_o[k] = w_hsk;
         end
      end
   end

   // Next-state logic: IDLE arbitrates, GRANT holds until the burst ends,
   // the requester releases after a handshake, or keeps waiting on a stall.
   always_comb begin
      w_state_nxt     = r_state;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_grant_id_nxt  = r_grant_id;
      w_burst_cnt_nxt = r_burst_cnt;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_state_nxt     = GRANT;
               w_grant_id_nxt  = w_winner;
               w_burst_cnt_nxt = '0;
            end
         end
         GRANT: begin
            if (w_hsk && w_last_beat) begin
               w_state_nxt     = IDLE;
               w_rr_ptr_nxt    = w_grant_inc;
               w_burst_cnt_nxt = '0;
            end else if (w_hsk) begin
               w_burst_cnt_nxt = r_burst_cnt + 1'b1;
            end else if (!w_req_g) begin
               // Requester finished its burst early.
               w_state_nxt     = IDLE;
               w_rr_ptr_nxt    = w_grant_inc;
               w_burst_cnt_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_grant_id  <= '0;
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_grant_id  <= w_grant_id_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: directed checks on a 4-requester instance and a
// randomized reference-model run on a 3-requester instance with MAX_BURST=2.
module tb_fifo_push_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // 4-requester instance, default parameters
   logic [3:0]  req4 = '0;
   logic [15:0] data4 = '0;
   logic [3:0]  ack4;
   logic        pr4;
   logic [3:0]  dat4;
   logic        pa4 = 1'b0;
   logic        gv4;
   logic [1:0]  gid4;

   // 3-requester instance
   logic [2:0]  req3 = '0;
   logic [11:0] data3 = '0;
   logic [2:0]  ack3;
   logic        pr3;
   logic [3:0]  dat3;
   logic        pa3 = 1'b0;
   logic        gv3;
   logic [1:0]  gid3;

   fifo_push_arbiter u4 (
      .clk(clk), .reset(reset), .req_i(req4), .data_i(data4), .ack_o(ack4),
      .fifo_push_req(pr4), .fifo_data_in(dat4), .fifo_push_ack(pa4),
      .grant_valid(gv4), .grant_id(gid4));

   fifo_push_arbiter #(.N_REQ(3), .WIDTH(4), .IDW(2), .MAX_BURST(2), .BCW(2)) u3 (
      .clk(clk), .reset(reset), .req_i(req3), .data_i(data3), .ack_o(ack3),
      .fifo_push_req(pr3), .fifo_data_in(dat3), .fifo_push_ack(pa3),
      .grant_valid(gv3), .grant_id(gid3));

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req4 = '0; pa4 = 1'b0; req3 = '0; pa3 = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // directed-test bookkeeping
   int   order[$];
   int   acks[$];
   logic prev_gv;

   // reference model for the 3-requester run
   localparam int N3 = 3;
   localparam int MB3 = 2;
   int         own, cnt, ptr, w;
   bit   [2:0] pend;
   logic [3:0] d [3];
   logic [3:0] sent_q [3][$];
   int         wcnt [3];
   logic       ev, epr, hsk;
   int         eg;
   logic [3:0] edat, exp_d;
   logic [2:0] eack;
   logic       prev_gv3;

   initial begin
      // ---- reset state ----
      data4 = 16'hFFFF;
      #1;
      chk("rst_gv", gv4, 0);
      chk("rst_req", pr4, 0);
      chk("rst_ack", ack4, 0);
      chk("rst_data", dat4, 0);
      chk("rst_gid", gid4, 0);

      // ---- single requester 2, four handshakes, IDLE, re-grant ----
      do_reset();
      @(negedge clk); req4 = 4'b0100; data4 = 16'h0A00; pa4 = 1'b1;
      #1 chk("t1_idle_req", pr4, 0);
      @(negedge clk); #1;
      chk("t1_gid", gid4, 2);
      chk("t1_gv", gv4, 1);
      chk("t1_req", pr4, 1);
      chk("t1_data", dat4, 4'hA);
      chk("t1_ack", ack4, 4'b0100);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1 chk("t1_ack_burst", ack4, 4'b0100);
      end
      @(negedge clk); #1 chk("t1_idle_gap", gv4, 0);
      @(negedge clk); #1;
      chk("t1_regrant_gv", gv4, 1);
      chk("t1_regrant_gid", gid4, 2);

      // ---- all four requesting, no stalls ----
      do_reset();
      @(negedge clk); req4 = 4'hF; data4 = 16'h4321; pa4 = 1'b1;
      prev_gv = 1'b0;
      for (int i = 0; i < 25; i++) begin
         #1;
         if (gv4 && !prev_gv) begin
            order.push_back(int'(gid4));
            acks.push_back(0);
         end
         if (ack4 != 0) begin
            chk("t2_onehot", $onehot(ack4), 1);
            if (acks.size() > 0) begin
               acks[acks.size()-1] += 1;
               chk("t2_data", dat4, 4'(order[order.size()-1] + 1));
            end
         end
         prev_gv = gv4;
         @(negedge clk);
      end
      chk("t2_periods", order.size(), 5);
      for (int p = 0; p < order.size() && p < 5; p++) begin
         chk("t2_order", order[p], p % 4);
         chk("t2_acks", acks[p], 4);
      end

      // ---- FIFO full stall on requester 1 ----
      do_reset();
      @(negedge clk); req4 = 4'b0010; data4 = 16'h0050; pa4 = 1'b0;
      #1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         chk("t3_gid", gid4, 1);
         chk("t3_req", pr4, 1);
         chk("t3_data", dat4, 4'h5);
         chk("t3_ack", ack4, 0);
      end
      @(negedge clk); pa4 = 1'b1;
      #1 chk("t3_ack11", ack4, 4'b0010);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1 chk("t3_ack_rest", ack4, 4'b0010);
      end
      @(negedge clk); #1 chk("t3_idle", gv4, 0);

      // ---- early release by requester 3, wrap to 0 ----
      do_reset();
      @(negedge clk); req4 = 4'b1000; data4 = 16'h7000; pa4 = 1'b1;
      #1;
      @(negedge clk); #1;
      chk("t4_gid", gid4, 3);
      chk("t4_ack1", ack4, 4'b1000);
      @(negedge clk); #1 chk("t4_ack2", ack4, 4'b1000);
      @(negedge clk); req4 = 4'b0001; data4 = 16'h7001;
      #1;
      chk("t4_rel_req", pr4, 0);
      chk("t4_rel_ack", ack4, 0);
      @(negedge clk); req4 = 4'b1001;
      #1 chk("t4_idle", gv4, 0);
      @(negedge clk); #1;
      chk("t4_wrap_gid", gid4, 0);
      chk("t4_wrap_ack", ack4, 4'b0001);

      // ---- asynchronous reset mid-grant ----
      do_reset();
      @(negedge clk); req4 = 4'b0100; data4 = 16'h0300; pa4 = 1'b0;
      #1;
      @(negedge clk); #1;
      chk("t5_pre_req", pr4, 1);
      #1 pa4 = 1'b1;
      #1 chk("t5_pre_ack", ack4, 4'b0100);
      #1 reset = 1'b1;
      #1;
      chk("t5_rst_req", pr4, 0);
      chk("t5_rst_ack", ack4, 0);
      chk("t5_rst_gv", gv4, 0);
      pa4 = 1'b0; req4 = 4'b0101; data4 = 16'h0309;
      @(negedge clk); reset = 1'b0;
      #1 chk("t5_post_idle", gv4, 0);
      @(negedge clk); #1 chk("t5_post_gid", gid4, 0);

      // ---- randomized run, N_REQ=3, MAX_BURST=2, random stalls ----
      do_reset();
      own = -1; cnt = 0; ptr = 0; pend = '0; prev_gv3 = 1'b0;
      for (int k = 0; k < N3; k++) begin d[k] = '0; wcnt[k] = 0; end
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         // fairness, measured on the DUT's own grant starts
         if (gv3 && !prev_gv3) begin
            for (int k = 0; k < N3; k++)
               if (pend[k] && k != int'(gid3)) wcnt[k]++;
            if (int'(gid3) < N3) chk("rnd_fair", wcnt[gid3] <= N3 - 1, 1);
         end
         prev_gv3 = gv3;
         // drive: a requester holds its request until acked
         for (int k = 0; k < N3; k++) begin
            if (!pend[k] && $urandom_range(0, 2) != 0) begin
               pend[k] = 1'b1;
               d[k]    = 4'($urandom);
               sent_q[k].push_back(d[k]);
               wcnt[k] = 0;
            end
         end
         req3  = pend;
         data3 = {d[2], d[1], d[0]};
         pa3   = ($urandom_range(0, 3) != 0);
         #1;
         // expected outputs from the model
         ev   = (own >= 0);
         eg   = ev ? own : 0;
         epr  = ev && pend[eg];
         edat = ev ? d[eg] : 4'h0;
         hsk  = epr && pa3;
         eack = hsk ? 3'(1 << eg) : 3'b000;
         chk("rnd_gv", gv3, ev);
         chk("rnd_gid", gid3, eg);
         chk("rnd_req", pr3, epr);
         chk("rnd_data", dat3, edat);
         chk("rnd_ack", ack3, eack);
         if (hsk && sent_q[eg].size() > 0) begin
            exp_d = sent_q[eg].pop_front();
            chk("rnd_order", dat3, exp_d);
         end
         // advance the model across the coming rising edge
         if (own < 0) begin
            if (pend != 0) begin
               w = -1;
               for (int i = N3 - 1; i >= 0; i--)
                  if (pend[(ptr + i) % N3]) w = (ptr + i) % N3;
               own = w;
               cnt = 0;
            end
         end else if (hsk) begin
            cnt++;
            pend[own] = 1'b0;
            if (cnt == MB3) begin
               ptr = (own + 1) % N3;
               own = -1;
            end
         end else if (!pend[own]) begin
            ptr = (own + 1) % N3;
            own = -1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
